// File: rtl/dma_regfile_mc.sv
// Multi-channel DMA register file on APB: per-channel descriptors, start/busy/done
// tracking, saturating completion counters and a masked write-1-to-clear interrupt.
module dma_regfile_mc #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 24,
  parameter int SIZE_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     pclken,
  input  logic                     psel,
  input  logic                     penable,
  input  logic [ADDR_W-1:0]        paddr,
  input  logic                     pwrite,
  input  logic [DATA_W-1:0]        pwdata,
  output logic [DATA_W-1:0]        prdata,
  output logic                     pslverr,
  output logic                     pready,
  input  logic [NUM_CH*SIZE_W-1:0] buffer_count,
  input  logic [NUM_CH-1:0]        ch_done,
  output logic [NUM_CH*ADDR_W-1:0] rd_start_addr,
  output logic [NUM_CH*ADDR_W-1:0] wr_start_addr,
  output logic [NUM_CH*SIZE_W-1:0] buffer_size,
  output logic [NUM_CH-1:0]        cmd_last,
  output logic [NUM_CH-1:0]        ch_start,
  output logic                     irq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACC_WR,
    S_ACC_RD1,
    S_ACC_RD2
  } apb_state_e;

  typedef enum logic [3:0] {
    R_NONE,
    R_RD_ADDR,
    R_WR_ADDR,
    R_SIZE,
    R_CTRL,
    R_STATUS,
    R_COUNT,
    R_INT_STATUS,
    R_INT_MASK
  } reg_sel_e;

  apb_state_e state_q, state_d;

  logic [ADDR_W-1:0] rd_addr_q [NUM_CH];
  logic [ADDR_W-1:0] rd_addr_d [NUM_CH];
  logic [ADDR_W-1:0] wr_addr_q [NUM_CH];
  logic [ADDR_W-1:0] wr_addr_d [NUM_CH];
  logic [SIZE_W-1:0] size_q    [NUM_CH];
  logic [SIZE_W-1:0] size_d    [NUM_CH];
  logic [7:0]        int_cnt_q [NUM_CH];
  logic [7:0]        int_cnt_d [NUM_CH];

  logic [NUM_CH-1:0] busy_q, busy_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] int_en_q, int_en_d;
  logic [NUM_CH-1:0] last_q, last_d;
  logic [NUM_CH-1:0] ch_start_q, ch_start_d;
  logic [NUM_CH-1:0] int_status_q, int_status_d;
  logic [NUM_CH-1:0] int_mask_q, int_mask_d;
  logic              irq_q, irq_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              rd_err_q, rd_err_d;

  reg_sel_e          sel;
  logic [2:0]        sel_ch;
  logic              sel_busy;
  logic              wr_err;
  logic              wr_fire;
  logic              wr_ok;
  logic              rd_capture;
  logic [DATA_W-1:0] rd_data;
  logic              unused_pwdata;

  assign unused_pwdata = ^pwdata;

  // Address decode: channel windows below 0x100, global registers at 0x100/0x104.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel    = R_NONE;
    sel_ch = paddr[7:5];
    if (paddr[ADDR_W-1:9] == '0) begin
      if (paddr[8]) begin
        if (paddr[7:0] == 8'h00)      sel = R_INT_STATUS;
        else if (paddr[7:0] == 8'h04) sel = R_INT_MASK;
      end else if (int'(sel_ch) < NUM_CH) begin
        case (paddr[4:0])
          5'h00:   sel = R_RD_ADDR;
          5'h04:   sel = R_WR_ADDR;
          5'h08:   sel = R_SIZE;
          5'h0C:   sel = R_CTRL;
          5'h10:   sel = R_STATUS;
          5'h14:   sel = R_COUNT;
          default: sel = R_NONE;
        endcase
      end
    end
  end

  always_comb begin
    sel_busy = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_ch == 3'(c)) sel_busy = busy_q[c];
    end
  end

  // Busy is judged on the registered state, so a completion in the same cycle
  // still rejects the access.
  always_comb begin
    wr_err = 1'b0;
    case (sel)
      R_NONE, R_COUNT:   wr_err = 1'b1;
      R_RD_ADDR, R_SIZE: wr_err = sel_busy;
      R_CTRL:            wr_err = sel_busy & pwdata[0];
      default:           wr_err = 1'b0;
    endcase
  end

  assign wr_fire    = (state_q == S_ACC_WR) && pclken && psel;
  assign wr_ok      = wr_fire && !wr_err;
  assign rd_capture = (state_q == S_ACC_RD1) && pclken && psel;

  always_comb begin
    state_d = state_q;
    if (pclken) begin
      case (state_q)
        S_IDLE:    if (psel && !penable) state_d = S_SETUP;
        S_SETUP: begin
          if (!psel)        state_d = S_IDLE;
          else if (penable) state_d = pwrite ? S_ACC_WR : S_ACC_RD1;
        end
        S_ACC_WR:  state_d = S_IDLE;
        S_ACC_RD1: state_d = psel ? S_ACC_RD2 : S_IDLE;
        S_ACC_RD2: state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_ch == 3'(c)) begin
        case (sel)
          R_RD_ADDR: rd_data[ADDR_W-1:0] = rd_addr_q[c];
          R_WR_ADDR: rd_data[ADDR_W-1:0] = wr_addr_q[c];
          R_SIZE:    rd_data[SIZE_W-1:0] = size_q[c];
          R_CTRL:    rd_data[2:1]        = {last_q[c], int_en_q[c]};
          R_STATUS: begin
            rd_data[15:8] = int_cnt_q[c];
            rd_data[1]    = done_q[c];
            rd_data[0]    = busy_q[c];
          end
          R_COUNT:   rd_data[SIZE_W-1:0] = buffer_count[c*SIZE_W +: SIZE_W];
          default:   ;
        endcase
      end
    end
    if (sel == R_INT_STATUS) rd_data[NUM_CH-1:0] = int_status_q;
    if (sel == R_INT_MASK)   rd_data[NUM_CH-1:0] = int_mask_q;
  end

  assign prdata_d = rd_capture ? rd_data : prdata_q;
  assign rd_err_d = rd_capture ? (sel == R_NONE) : rd_err_q;
  assign irq_d    = |(int_status_q & int_mask_q);

  // Bus writes are applied before engine completions so a same-cycle done
  // overrides a write-1-to-clear of the same bit.
  always_comb begin
    rd_addr_d    = rd_addr_q;
    wr_addr_d    = wr_addr_q;
    size_d       = size_q;
    int_cnt_d    = int_cnt_q;
    busy_d       = busy_q;
    done_d       = done_q;
    int_en_d     = int_en_q;
    last_d       = last_q;
    ch_start_d   = '0;
    int_status_d = int_status_q;
    int_mask_d   = int_mask_q;

    if (wr_ok && sel == R_INT_STATUS) int_status_d = int_status_q & ~pwdata[NUM_CH-1:0];
    if (wr_ok && sel == R_INT_MASK)   int_mask_d   = pwdata[NUM_CH-1:0];

    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_ok && sel_ch == 3'(c)) begin
        case (sel)
          R_RD_ADDR: rd_addr_d[c] = pwdata[ADDR_W-1:0];
          R_WR_ADDR: if (!busy_q[c]) wr_addr_d[c] = pwdata[ADDR_W-1:0];
          R_SIZE:    size_d[c] = pwdata[SIZE_W-1:0];
          R_CTRL: begin
            int_en_d[c] = pwdata[1];
            if (!busy_q[c]) last_d[c] = pwdata[2];
            if (pwdata[0]) begin
              busy_d[c]     = 1'b1;
              ch_start_d[c] = 1'b1;
            end
          end
          R_STATUS: begin
            if (pwdata[1])  done_d[c]    = 1'b0;
            if (pwdata[31]) int_cnt_d[c] = '0;
          end
          default: ;
        endcase
      end
      if (ch_done[c] && busy_q[c]) begin
        busy_d[c] = 1'b0;
        done_d[c] = 1'b1;
        if (int_cnt_d[c] != 8'hFF) int_cnt_d[c] = int_cnt_d[c] + 8'd1;
        if (int_en_q[c]) int_status_d[c] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      // NOTE: the descriptor arrays are reset in full; software and engines read them straight after reset.
      rd_addr_q    <= '{default: '0};
      wr_addr_q    <= '{default: '0};
      size_q       <= '{default: '0};
      int_cnt_q    <= '{default: '0};
      busy_q       <= '0;
      done_q       <= '0;
      int_en_q     <= '0;
      last_q       <= '0;
      ch_start_q   <= '0;
      int_status_q <= '0;
      int_mask_q   <= '0;
      irq_q        <= 1'b0;
      prdata_q     <= '0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_addr_q    <= rd_addr_d;
      wr_addr_q    <= wr_addr_d;
      size_q       <= size_d;
      int_cnt_q    <= int_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      int_en_q     <= int_en_d;
      last_q       <= last_d;
      ch_start_q   <= ch_start_d;
      int_status_q <= int_status_d;
      int_mask_q   <= int_mask_d;
      irq_q        <= irq_d;
      prdata_q     <= prdata_d;
      rd_err_q     <= rd_err_d;
    end
  end

  always_comb begin
    rd_start_addr = '0;
    wr_start_addr = '0;
    buffer_size   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      rd_start_addr[c*ADDR_W +: ADDR_W] = rd_addr_q[c];
      wr_start_addr[c*ADDR_W +: ADDR_W] = wr_addr_q[c];
      buffer_size[c*SIZE_W +: SIZE_W]   = size_q[c];
    end
  end

  assign cmd_last = last_q;
  assign ch_start = ch_start_q;
  assign irq      = irq_q;
  assign prdata   = prdata_q;
  assign pready   = ((state_q == S_ACC_WR) && psel) || (state_q == S_ACC_RD2);
  assign pslverr  = ((state_q == S_ACC_WR) && psel && wr_err) ||
                    ((state_q == S_ACC_RD2) && rd_err_q);

endmodule

// File: tb/tb_dma_regfile_mc.sv
// Directed bench for dma_regfile_mc: APB timing, descriptor protection, done/irq
// handling, error responses and completion-counter saturation.
module tb_dma_regfile_mc;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 24;
  localparam int SIZE_W = 16;
  localparam int DATA_W = 32;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     pclken;
  logic                     psel;
  logic                     penable;
  logic [ADDR_W-1:0]        paddr;
  logic                     pwrite;
  logic [DATA_W-1:0]        pwdata;
  logic [DATA_W-1:0]        prdata;
  logic                     pslverr;
  logic                     pready;
  logic [NUM_CH*SIZE_W-1:0] buffer_count;
  logic [NUM_CH-1:0]        ch_done;
  logic [NUM_CH*ADDR_W-1:0] rd_start_addr;
  logic [NUM_CH*ADDR_W-1:0] wr_start_addr;
  logic [NUM_CH*SIZE_W-1:0] buffer_size;
  logic [NUM_CH-1:0]        cmd_last;
  logic [NUM_CH-1:0]        ch_start;
  logic                     irq;

  int errors = 0;
  int checks = 0;

  logic [31:0] rdata;
  logic        err;
  int          waits;

  dma_regfile_mc #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset), .pclken(pclken), .psel(psel), .penable(penable),
    .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
    .pslverr(pslverr), .pready(pready), .buffer_count(buffer_count),
    .ch_done(ch_done), .rd_start_addr(rd_start_addr), .wr_start_addr(wr_start_addr),
    .buffer_size(buffer_size), .cmd_last(cmd_last), .ch_start(ch_start), .irq(irq)
  );

  always #5 clk = ~clk;

  // One APB transfer; done_mask is pulsed on ch_done during the completing ACCESS cycle.
  task automatic apb_xfer(input logic wr, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                          input logic [NUM_CH-1:0] done_mask,
                          output logic [31:0] rd, output logic er, output int nw);
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    nw = 0;
    @(negedge clk);
    while (!pready && nw < 8) begin
      nw++;
      @(negedge clk);
    end
    checks++;
    if (pready !== 1'b1) begin
      errors++;
      $display("FAIL apb_timeout addr=%h: pready=%b required 1", a, pready);
    end
    rd = prdata;
    er = pslverr;
    ch_done = done_mask;
    @(negedge clk);
    ch_done = '0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; pclken = 1'b1; psel = 1'b0; penable = 1'b0; paddr = '0;
    pwrite = 1'b0; pwdata = '0; ch_done = '0;
    buffer_count = {16'h0000, 16'h0000, 16'hBEEF, 16'h0000};
    repeat (3) @(negedge clk);
    checks++;
    if ({prdata, pready, pslverr, ch_start, irq} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: prdata=%h pready=%b pslverr=%b ch_start=%b irq=%b required all 0",
               prdata, pready, pslverr, ch_start, irq);
    end
    checks++;
    if ({rd_start_addr, wr_start_addr, buffer_size, cmd_last} !== '0) begin
      errors++;
      $display("FAIL reset_descriptors: rd=%h wr=%h size=%h last=%b required 0",
               rd_start_addr, wr_start_addr, buffer_size, cmd_last);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read;
    apb_xfer(1'b1, 24'h000, 32'h0000_0ABC, '0, rdata, err, waits);
    apb_xfer(1'b1, 24'h008, 32'h0000_0012, '0, rdata, err, waits);
    apb_xfer(1'b1, 24'h00C, 32'h0000_0004, '0, rdata, err, waits);
    checks++;
    if (cmd_last !== 4'b0001 || rd_start_addr[23:0] !== 24'hABC) begin
      errors++;
      $display("FAIL pre_reset_desc: last=%b rd0=%h required 0001/abc", cmd_last, rd_start_addr[23:0]);
    end
    apb_xfer(1'b0, 24'h000, '0, '0, rdata, err, waits);
    checks++;
    if (rdata !== 32'h0000_0ABC) begin
      errors++;
      $display("FAIL pre_reset_read: got %h required 00000abc", rdata);
    end
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 24'h008;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    checks++;
    if (pready !== 1'b0) begin
      errors++;
      $display("FAIL mid_read_wait: pready=%b required 0", pready);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (prdata !== '0 || pready !== 1'b0 || rd_start_addr !== '0 || buffer_size !== '0 || cmd_last !== '0) begin
      errors++;
      $display("FAIL reset_mid_read: prdata=%h pready=%b rd=%h size=%h last=%b required 0",
               prdata, pready, rd_start_addr, buffer_size, cmd_last);
    end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    apb_xfer(1'b0, 24'h008, '0, '0, rdata, err, waits);
    checks++;
    if (rdata !== 32'h0 || waits != 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_read: data=%h waits=%0d err=%b required 0/1/0", rdata, waits, err);
    end
  endtask

  task automatic test_start_busy;
    apb_xfer(1'b1, 24'h020, 32'h0000_0100, '0, rdata, err, waits);
    apb_xfer(1'b1, 24'h024, 32'h0000_0200, '0, rdata, err, waits);
    apb_xfer(1'b1, 24'h028, 32'h0000_0040, '0, rdata, err, waits);
    apb_xfer(1'b1, 24'h104, 32'h0000_0002, '0, rdata, err, waits);
    checks++;
    if (waits != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL write_timing: waits=%0d err=%b required 0/0", waits, err);
    end
    apb_xfer(1'b1, 24'h02C, 32'h0000_0003, '0, rdata, err, waits);
    checks++;
    if (ch_start !== 4'b0010) begin
      errors++;
      $display("FAIL ch_start_pulse: got %b required 0010", ch_start);
    end
    @(negedge clk);
    checks++;
    if (ch_start !== 4'b0000) begin
      errors++;
      $display("FAIL ch_start_width: got %b required 0000", ch_start);
    end
    checks++;
    if (rd_start_addr[47:24] !== 24'h100 || wr_start_addr[47:24] !== 24'h200 || buffer_size[31:16] !== 16'h40) begin
      errors++;
      $display("FAIL ch1_desc: rd=%h wr=%h size=%h required 100/200/40",
               rd_start_addr[47:24], wr_start_addr[47:24], buffer_size[31:16]);
    end
    apb_xfer(1'b0, 24'h030, '0, '0, rdata, err, waits);
    checks++;
    if (rdata !== 32'h0000_0001) begin
      errors++;
      $display("FAIL ch1_status_busy: got %h required 00000001", rdata);
    end
    apb_xfer(1'b1, 24'h020, 32'h0000_0555, '0, rdata, err, waits);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL busy_write_err: pslverr=%b required 1", err);
    end
    apb_xfer(1'b0, 24'h020, '0, '0, rdata, err, waits);
    checks++;
    if (rdata !== 32'h0000_0100) begin
      errors++;
      $display("FAIL busy_write_kept: got %h required 00000100", rdata);
    end
  endtask

  task automatic test_done_irq;
    @(negedge clk);
    ch_done = 4'b0010;
    @(negedge clk);
    ch_done = '0;
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_latency: irq=%b required 0", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_rise: irq=%b required 1", irq);
    end
    apb_xfer(1'b0, 24'h030, '0, '0, rdata, err, waits);
    checks++;
    if (rdata !== 32'h0000_0102) begin
      errors++;
      $display("FAIL ch1_status_done: got %h required 00000102", rdata);
    end
    apb_xfer(1'b0, 24'h100, '0, '0, rdata, err, waits);
    checks++;
    if (rdata !== 32'h0000_0002) begin
      errors++;
      $display("FAIL int_status_set: got %h required 00000002", rdata);
    end
    apb_xfer(1'b1, 24'h100, 32'h0000_0002, '0, rdata, err, waits);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL irq_hold: irq=%b required 1", irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL irq_fall: irq=%b required 0", irq);
    end
  endtask

  task automatic test_collisions;
    apb_xfer(1'b1, 24'h02C, 32'h0000_0003, '0, rdata, err, waits);
    apb_xfer(1'b1, 24'h100, 32'h0000_0002, 4'b0010, rdata, err, waits);
    apb_xfer(1'b0, 24'h100, '0, '0, rdata, err, waits);
    checks++;
    if (rdata !== 32'h0000_0002) begin
      errors++;
      $display("FAIL done_beats_w1c: got %h required 00000002", rdata);
    end
    apb_xfer(1'b1, 24'h100, 32'h0000_0002, '0, rdata, err, waits);
    apb_xfer(1'b0, 24'h100, '0, '0, rdata, err, waits);
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL w1c_clear: got %h required 00000000", rdata);
    end
    apb_xfer(1'b1, 24'h02C, 32'h0000_0003, '0, rdata, err, waits);
    apb_xfer(1'b1, 24'h02C, 32'h0000_0003, 4'b0010, rdata, err, waits);
    checks++;
    if (err !== 1'b1 || ch_start !== 4'b0000) begin
      errors++;
      $display("FAIL done_vs_start: pslverr=%b ch_start=%b required 1/0000", err, ch_start);
    end
    apb_xfer(1'b0, 24'h030, '0, '0, rdata, err, waits);
    checks++;
    if (rdata !== 32'h0000_0302) begin
      errors++;
      $display("FAIL done_vs_start_status: got %h required 00000302", rdata);
    end
  endtask

  task automatic test_errors;
    apb_xfer(1'b0, 24'h0C4, '0, '0, rdata, err, waits);
    checks++;
    if (err !== 1'b1 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL bad_channel_read: pslverr=%b data=%h required 1/0", err, rdata);
    end
    apb_xfer(1'b0, 24'h0FC, '0, '0, rdata, err, waits);
    checks++;
    if (err !== 1'b1 || rdata !== 32'h0 || waits != 1) begin
      errors++;
      $display("FAIL unmapped_read: pslverr=%b data=%h waits=%0d required 1/0/1", err, rdata, waits);
    end
    apb_xfer(1'b1, 24'h034, 32'h0000_1234, '0, rdata, err, waits);
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL ro_write: pslverr=%b required 1", err);
    end
    apb_xfer(1'b0, 24'h034, '0, '0, rdata, err, waits);
    checks++;
    if (err !== 1'b0 || rdata !== 32'h0000_BEEF) begin
      errors++;
      $display("FAIL buffer_count_read: pslverr=%b data=%h required 0/0000beef", err, rdata);
    end
    apb_xfer(1'b0, 24'h104, '0, '0, rdata, err, waits);
    checks++;
    if (rdata !== 32'h0000_0002) begin
      errors++;
      $display("FAIL int_mask_read: got %h required 00000002", rdata);
    end
  endtask

  task automatic test_pclken_stall;
    @(negedge clk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 24'h020; pclken = 1'b0;
    @(negedge clk);
    pclken = 1'b1;
    @(negedge clk);
    penable = 1'b1; pclken = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pready !== 1'b0) begin
      errors++;
      $display("FAIL stall_setup: pready=%b required 0", pready);
    end
    pclken = 1'b1;
    @(negedge clk);
    pclken = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (pready !== 1'b0) begin
      errors++;
      $display("FAIL stall_wait_state: pready=%b required 0", pready);
    end
    pclken = 1'b1;
    @(negedge clk);
    checks++;
    if (pready !== 1'b1 || prdata !== 32'h0000_0100) begin
      errors++;
      $display("FAIL stall_complete: pready=%b data=%h required 1/00000100", pready, prdata);
    end
    @(negedge clk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_saturation;
    int bad;
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      apb_xfer(1'b1, 24'h00C, 32'h0000_0001, '0, rdata, err, waits);
      if (err !== 1'b0) bad++;
      @(negedge clk);
      ch_done = 4'b0001;
      @(negedge clk);
      ch_done = '0;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL restart_errors: got %0d required 0", bad);
    end
    apb_xfer(1'b0, 24'h010, '0, '0, rdata, err, waits);
    checks++;
    if (rdata !== 32'h0000_FF02) begin
      errors++;
      $display("FAIL int_count_sat: got %h required 0000ff02", rdata);
    end
    apb_xfer(1'b1, 24'h010, 32'h8000_0000, '0, rdata, err, waits);
    apb_xfer(1'b0, 24'h010, '0, '0, rdata, err, waits);
    checks++;
    if (rdata !== 32'h0000_0002) begin
      errors++;
      $display("FAIL int_count_clear: got %h required 00000002", rdata);
    end
    apb_xfer(1'b1, 24'h010, 32'h0000_0002, '0, rdata, err, waits);
    apb_xfer(1'b0, 24'h010, '0, '0, rdata, err, waits);
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL done_w1c: got %h required 00000000", rdata);
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_read;
    test_start_busy;
    test_done_irq;
    test_collisions;
    test_errors;
    test_pclken_stall;
    test_saturation;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
